input_limit_fifo: RTL and testbench

Synchronous 16-bit input FIFO on the inbound, host-to-FPGA path. It is the counterpart of the output-limit path. Words arrive from the USB endpoint interface and are buffered in block RAM. They are presented first-word-fall-through to the cores' input distributor. In limit mode, the host grants a word quota and writes beyond the granted quota are refused, so the host can pace traffic against its own accounting.

---
 rtl/input_limit_fifo_if.sv | 28 ++
 rtl/input_limit_fifo.sv | 97 +++++++++
 tb/tb_input_limit_fifo.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/input_limit_fifo_if.sv
// Handshake bundle between the endpoint/host side and the input-limit FIFO.
// The master modport is the traffic source and consumer; the FIFO uses the slave modport.
interface input_limit_fifo_if #(
    parameter int ADDR_MSB = 10
);
    logic [15:0]         din;
    logic                wr_en;
    logic                full;
    logic [15:0]         dout;
    logic                rd_en;
    logic                empty;
    logic                mode_limit;
    logic                reg_input_limit;
    logic [15:0]         input_limit;
    logic [15:0]         input_limit_remain;
    logic                input_limit_not_done;
    logic [ADDR_MSB+1:0] free_words;

    modport master (
        output din, wr_en, rd_en, mode_limit, reg_input_limit, input_limit,
        input  full, dout, empty, input_limit_remain, input_limit_not_done, free_words
    );

    modport slave (
        input  din, wr_en, rd_en, mode_limit, reg_input_limit, input_limit,
        output full, dout, empty, input_limit_remain, input_limit_not_done, free_words
    );
endinterface

// File: rtl/input_limit_fifo.sv
// Host-to-FPGA input FIFO: RAM buffer with a first-word-fall-through output register
// and an optional host-granted write quota that refuses writes once exhausted.
module input_limit_fifo #(
    parameter int ADDR_MSB = 10
) (
    input logic                CLK,
    input logic                rst,
    input_limit_fifo_if.slave  bus
);
    localparam int AW    = ADDR_MSB + 1;
    localparam int CW    = ADDR_MSB + 2;
    localparam int DEPTH = 1 << AW;

    localparam logic [CW-1:0] DEPTH_C = {1'b1, {AW{1'b0}}};
    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};

    logic [15:0]   ram_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] ram_cnt_s;
    logic          out_valid_q, out_valid_d;
    logic [15:0]   dout_q, dout_d;
    logic [15:0]   remain_q, remain_d;
    logic [15:0]   quota_base_s;
    logic          full_s, wa_s, ra_s, load_s;

    // Accept decisions, output-register refill and quota accounting from pre-edge state
    always_comb begin
        full_s    = (cnt_q == DEPTH_C) | (bus.mode_limit & (remain_q == 16'd0));
        wa_s      = bus.wr_en & ~full_s;
        ra_s      = bus.rd_en & out_valid_q;
        // Words still sitting in RAM; the output register word is excluded
        ram_cnt_s = cnt_q - {{(CW-1){1'b0}}, out_valid_q};
        load_s    = (~out_valid_q | ra_s) & (ram_cnt_s != {CW{1'b0}});

        wr_ptr_d  = wa_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d  = load_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        dout_d    = load_s ? ram_q[rd_ptr_q] : dout_q;

        case ({wa_s, ra_s})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase

        if (load_s) begin
            out_valid_d = 1'b1;
        end else if (ra_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end

        // A fresh grant landing with an accepted write is charged for that write
        quota_base_s = bus.reg_input_limit ? bus.input_limit : remain_q;
        if (bus.mode_limit & wa_s & (quota_base_s != 16'd0)) begin
            remain_d = quota_base_s - 16'd1;
        end else begin
            remain_d = quota_base_s;
        end
    end

    // Control and output registers, all cleared asynchronously
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= {AW{1'b0}};
            rd_ptr_q    <= {AW{1'b0}};
            cnt_q       <= {CW{1'b0}};
            out_valid_q <= 1'b0;
            dout_q      <= 16'd0;
            remain_q    <= 16'd0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            dout_q      <= dout_d;
            remain_q    <= remain_d;
        end
    end

    // Storage array; contents are don't-care after reset since pointers restart
    always_ff @(posedge CLK) begin
        if (wa_s) begin
            ram_q[wr_ptr_q] <= bus.din;
        end
    end

    assign bus.full                 = full_s;
    assign bus.dout                 = dout_q;
    assign bus.empty                = ~out_valid_q;
    assign bus.input_limit_remain   = remain_q;
    assign bus.input_limit_not_done = bus.mode_limit & (remain_q != 16'd0);
    assign bus.free_words           = DEPTH_C - cnt_q;
endmodule

// File: tb/tb_input_limit_fifo.sv
// Self-checking bench for input_limit_fifo at D=16: a queue-based reference model
// checked every cycle, a vector table for the quota path, and directed corner sequences.
module tb_input_limit_fifo;
    localparam int D = 16;

    logic CLK;
    logic rst;
    input_limit_fifo_if #(.ADDR_MSB(3)) bus ();

    input_limit_fifo #(.ADDR_MSB(3)) dut (
        .CLK (CLK),
        .rst (rst),
        .bus (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [15:0] data;
        int          edge_n;
    } ent_t;

    typedef struct {
        logic        wr;
        logic [15:0] din;
        logic        md;
        logic        rl;
        logic [15:0] lim;
        logic        e_empty;
        logic        e_full;
        logic [15:0] e_dout;
        logic [15:0] e_remain;
        logic        e_nd;
        logic [4:0]  e_free;
    } vec_t;

    ent_t        mq[$];
    int          edge_cnt;
    int          m_remain;
    logic [15:0] last_shown;
    logic        cur_mode;
    int          n_chk;
    int          n_err;
    vec_t        tbl[13];
    logic [15:0] got[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // A word accepted at edge e is in RAM after e and on dout after e+1
    function automatic bit m_empty();
        return (mq.size() == 0) || (mq[0].edge_n >= edge_cnt - 1);
    endfunction

    task automatic compare_model();
        bit e;
        e = m_empty();
        if (!e) last_shown = mq[0].data;
        chk("m_empty", 32'(bus.empty), 32'(e));
        chk("m_dout", 32'(bus.dout), 32'(last_shown));
        chk("m_full", 32'(bus.full), 32'((mq.size() == D) || (cur_mode && m_remain == 0)));
        chk("m_remain", 32'(bus.input_limit_remain), 32'(m_remain));
        chk("m_not_done", 32'(bus.input_limit_not_done), 32'(cur_mode && m_remain != 0));
        chk("m_free", 32'(bus.free_words), 32'(D - mq.size()));
    endtask

    task automatic cyc(input logic wr, input logic rd, input logic [15:0] d,
                       input logic md, input logic rl, input logic [15:0] lim);
        bit mfull, wa, ra;
        int base;
        bus.wr_en = wr; bus.rd_en = rd; bus.din = d;
        bus.mode_limit = md; bus.reg_input_limit = rl; bus.input_limit = lim;
        cur_mode = md;
        mfull = (mq.size() == D) || (md && m_remain == 0);
        wa = wr && !mfull;
        ra = rd && !m_empty();
        @(posedge CLK);
        #1;
        if (ra) void'(mq.pop_front());
        if (wa) mq.push_back('{data: d, edge_n: edge_cnt});
        base = rl ? int'(lim) : m_remain;
        if (md && wa && base > 0) base--;
        m_remain = base;
        edge_cnt++;
        bus.reg_input_limit = 1'b0;
        compare_model();
    endtask

    task automatic do_reset(input logic md);
        bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.din = 16'd0;
        bus.reg_input_limit = 1'b0; bus.input_limit = 16'd0;
        bus.mode_limit = md; cur_mode = md;
        rst = 1'b1;
        #2;
        mq.delete();
        m_remain = 0;
        last_shown = 16'd0;
        chk("rst_empty", 32'(bus.empty), 32'd1);
        chk("rst_free", 32'(bus.free_words), 32'd16);
        chk("rst_remain", 32'(bus.input_limit_remain), 32'd0);
        chk("rst_full", 32'(bus.full), 32'(md));
        chk("rst_not_done", 32'(bus.input_limit_not_done), 32'd0);
        chk("rst_dout", 32'(bus.dout), 32'd0);
        @(negedge CLK);
        rst = 1'b0;
        @(posedge CLK);
        #1;
        edge_cnt++;
    endtask

    initial begin
        n_chk = 0; n_err = 0; edge_cnt = 0; m_remain = 0;
        last_shown = 16'd0; cur_mode = 1'b0; rst = 1'b1;

        // Quota vectors: grant 5, hold wr_en 10 cycles, then regrant and load-during-write
        tbl[0] = '{wr: 1'b0, din: 16'h0, md: 1'b1, rl: 1'b1, lim: 16'd5, e_empty: 1'b1,
                   e_full: 1'b0, e_dout: 16'h0, e_remain: 16'd5, e_nd: 1'b1, e_free: 5'd16};
        for (int i = 1; i <= 10; i++) begin
            tbl[i] = '{wr: 1'b1, din: 16'(16'hA0 + i), md: 1'b1, rl: 1'b0, lim: 16'd0,
                       e_empty: (i == 1), e_full: (i >= 5),
                       e_dout: (i == 1) ? 16'h0 : 16'hA1,
                       e_remain: 16'((i <= 5) ? (5 - i) : 0), e_nd: (i < 5),
                       e_free: 5'(16 - ((i <= 5) ? i : 5))};
        end
        tbl[11] = '{wr: 1'b0, din: 16'h0, md: 1'b1, rl: 1'b1, lim: 16'd2, e_empty: 1'b0,
                    e_full: 1'b0, e_dout: 16'hA1, e_remain: 16'd2, e_nd: 1'b1, e_free: 5'd11};
        tbl[12] = '{wr: 1'b1, din: 16'hB0, md: 1'b1, rl: 1'b1, lim: 16'd7, e_empty: 1'b0,
                    e_full: 1'b0, e_dout: 16'hA1, e_remain: 16'd6, e_nd: 1'b1, e_free: 5'd10};

        do_reset(1'b0);
        for (int i = 0; i < 13; i++) begin
            cyc(tbl[i].wr, 1'b0, tbl[i].din, tbl[i].md, tbl[i].rl, tbl[i].lim);
            chk($sformatf("t%0d_empty", i), 32'(bus.empty), 32'(tbl[i].e_empty));
            chk($sformatf("t%0d_full", i), 32'(bus.full), 32'(tbl[i].e_full));
            chk($sformatf("t%0d_dout", i), 32'(bus.dout), 32'(tbl[i].e_dout));
            chk($sformatf("t%0d_remain", i), 32'(bus.input_limit_remain), 32'(tbl[i].e_remain));
            chk($sformatf("t%0d_not_done", i), 32'(bus.input_limit_not_done), 32'(tbl[i].e_nd));
            chk($sformatf("t%0d_free", i), 32'(bus.free_words), 32'(tbl[i].e_free));
        end

        // Unlimited fill with 17 words, then drain
        do_reset(1'b0);
        for (int i = 0; i < 17; i++) begin
            cyc(1'b1, 1'b0, 16'(i + 1), 1'b0, 1'b0, 16'd0);
            if (i == 14) chk("fill_full15", 32'(bus.full), 32'd0);
            if (i == 15) chk("fill_full16", 32'(bus.full), 32'd1);
        end
        chk("fill_free", 32'(bus.free_words), 32'd0);
        got.delete();
        for (int i = 0; i < 20; i++) begin
            if (!bus.empty) got.push_back(bus.dout);
            cyc(1'b0, 1'b1, 16'd0, 1'b0, 1'b0, 16'd0);
        end
        chk("drain_count", 32'(got.size()), 32'd16);
        for (int i = 0; i < got.size() && i < 16; i++)
            chk($sformatf("drain_%0d", i), 32'(got[i]), 32'(i + 1));
        chk("drain_empty", 32'(bus.empty), 32'd1);
        chk("drain_free", 32'(bus.free_words), 32'd16);

        // Full with simultaneous read and write
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 16'(16'h200 + i), 1'b0, 1'b0, 16'd0);
        chk("sim_full_pre", 32'(bus.full), 32'd1);
        cyc(1'b1, 1'b1, 16'h2FF, 1'b0, 1'b0, 16'd0);
        chk("sim_free_1", 32'(bus.free_words), 32'd1);
        chk("sim_full_mid", 32'(bus.full), 32'd0);
        cyc(1'b1, 1'b1, 16'h2FE, 1'b0, 1'b0, 16'd0);
        chk("sim_free_2", 32'(bus.free_words), 32'd1);

        // Wrap-around streaming with continuous read
        do_reset(1'b0);
        got.delete();
        for (int i = 0; i < 100; i++) begin
            if (!bus.empty) got.push_back(bus.dout);
            cyc(1'b1, 1'b1, 16'(16'h1000 + i), 1'b0, 1'b0, 16'd0);
            if (i == 0) chk("wrap_lat_empty0", 32'(bus.empty), 32'd1);
            if (i == 1) begin
                chk("wrap_lat_empty1", 32'(bus.empty), 32'd0);
                chk("wrap_lat_dout", 32'(bus.dout), 32'h1000);
            end
        end
        for (int i = 0; i < 10; i++) begin
            if (!bus.empty) got.push_back(bus.dout);
            cyc(1'b0, 1'b1, 16'd0, 1'b0, 1'b0, 16'd0);
        end
        chk("wrap_count", 32'(got.size()), 32'd100);
        for (int i = 0; i < got.size() && i < 100; i++)
            chk($sformatf("wrap_%0d", i), 32'(got[i]), 32'(16'h1000 + i));

        // Reset in the middle of a quota-limited stream
        do_reset(1'b0);
        cyc(1'b0, 1'b0, 16'd0, 1'b1, 1'b1, 16'd12);
        for (int i = 0; i < 9; i++) cyc(1'b1, 1'b0, 16'(16'h300 + i), 1'b1, 1'b0, 16'd0);
        chk("mid_free", 32'(bus.free_words), 32'd7);
        chk("mid_remain", 32'(bus.input_limit_remain), 32'd3);
        do_reset(1'b1);
        cyc(1'b1, 1'b0, 16'h5A5A, 1'b0, 1'b0, 16'd0);
        chk("post_rst_empty0", 32'(bus.empty), 32'd1);
        cyc(1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 16'd0);
        chk("post_rst_empty1", 32'(bus.empty), 32'd0);
        chk("post_rst_dout", 32'(bus.dout), 32'h5A5A);

        // Random traffic with mode toggles and occasional quota grants
        begin
            logic md;
            md = 1'b0;
            for (int i = 0; i < 400; i++) begin
                if ($urandom_range(19, 0) == 0) md = ~md;
                cyc(($urandom_range(9, 0) < 7),
                    ($urandom_range(9, 0) < ((i < 200) ? 3 : 8)),
                    16'($urandom),
                    md,
                    ($urandom_range(11, 0) == 0),
                    16'($urandom_range(20, 0)));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
